spi_sram_master: RTL and testbench
==================================

Name: spi_sram_master

Overview:
- Host-side SPI master for the 23A640-style 8 KB serial SRAM.
- Accepts single-byte read/write requests on a valid/ready interface.
- Serialises each request as one SPI mode-0 frame on csb/sck/si: 8-bit instruction, 16-bit address, 8 data bits.
- Captures read data from so and returns one response per request.

Parameters:
- CLK_DIV, 2: clk cycles per sck half-period; legal values 1..255.
- CS_GAP, 2: minimum clk cycles csb stays high between frames; legal values 1..255.
- READ_INST, 8'h03: instruction byte sent for reads.
- WRITE_INST, 8'h02: instruction byte sent for writes.

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- rst, input, 1: synchronous active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request.
- req_write, input, 1: 1 = write, 0 = read.
- req_addr, input, 16: byte address; sent MSB first.
- req_wdata, input, 8: write data.
- rsp_valid, output, 1: one-cycle pulse, frame complete.
- rsp_rdata, output, 8: read byte; 0 for writes.
- rsp_err, output, 1: request rejected; qualified by rsp_valid.
- csb, output, 1: chip select, active low.
- sck, output, 1: SPI clock, idles low.
- si, output, 1: MOSI.
- so, input, 1: MISO.

Behaviour:
- Reset (rst low at a clk edge): csb=1, sck=0, si=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; state=IDLE. req_ready rises on the first edge after rst goes high.
- Reset mid-frame: the frame is abandoned, csb rises at that edge, and no response is produced.
- Handshake: a request is accepted when req_valid && req_ready at a clk edge. On that edge:
  - the 32-bit frame {instruction, req_addr, data} is latched, with data = req_wdata for writes and 8'h00 for reads;
  - req_ready drops and csb falls.
- Only one outstanding request; req_ready=1 only in IDLE.
- States and transitions: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- SHIFT: 32 bit-periods, each CLK_DIV cycles with sck low then CLK_DIV cycles with sck high.
  - si is updated at the start of each low phase: frame[31] first, MSB first.
  - The slave samples si on sck rising edges.
  - Read frames: bits 24..31 are captured from so at the clk edge where sck falls (end of high phase). Bit 24 goes to rsp_rdata[7].
  - The slave updates so on sck rising edges, so so is stable for the whole high phase.
  - si is held at 0 during the data phase of reads.
- HOLD: sck low for CLK_DIV cycles. At the HOLD exit edge, csb rises, rsp_valid=1 for exactly one cycle, and rsp_rdata is updated (reads: captured byte; writes: 0).
- GAP: csb high for CS_GAP cycles, then req_ready=1.
- Latency from the accept edge:
  - rsp_valid and csb-rise edge: 65*CLK_DIV cycles.
  - req_ready high: 65*CLK_DIV + CS_GAP cycles.
  - With the defaults: 130 and 132 cycles.
- No response backpressure: the host must accept rsp_valid whenever it pulses.
- sck never glitches: exactly 32 rising edges per frame. sck is low whenever csb changes.
- req_* inputs are ignored while req_ready=0. Changing them mid-frame has no effect.
- Bit and half-period counters use an explicit terminal-count compare, so CLK_DIV=1 works (sck = clk/2).

Optional Feature:
- Macro SPI_SRAM_MASTER_ADDR_CHECK_EN.
- Defined:
  - A request with req_addr[15:13] != 0 is accepted, but no frame is sent: csb stays high.
  - rsp_valid pulses with rsp_err=1 and rsp_rdata=0 exactly 2 cycles after the accept edge.
  - req_ready returns after CS_GAP further cycles.
- Not defined:
  - rsp_err is tied 0.
  - All 16 address bits are transmitted unchanged; the SRAM uses bits [12:0].

Test Plan:
- Write then read, defaults: write addr 16'h0123 data 8'hA5, then read 16'h0123.
  - si bitstream is 02,01,23,A5.
  - Each frame has exactly 32 sck rises.
  - Read returns rsp_rdata=8'hA5, rsp_valid at +130 cycles.
- Back-to-back with req_valid held high: 4 writes to 0x0000..0x0003.
  - csb stays high ≥ CS_GAP cycles between frames.
  - req_ready is low throughout each frame.
  - Read-back returns the same 4 bytes.
- CLK_DIV=1: read 16'h1FFF after writing 8'h3C → rsp_rdata=8'h3C, rsp_valid at +65 cycles.
- Reset at cycle 40 of a write to 16'h0010 data 8'hFF:
  - csb=1, sck=0 on the next edge, and no rsp_valid.
  - A later read of 0x0010 returns 8'h00.
- With SPI_SRAM_MASTER_ADDR_CHECK_EN: read 16'h2000 → rsp_err=1, rsp_rdata=0, no csb activity.
  - Without the macro: a frame is sent and the byte at 0x0000 is returned.

Source files
------------

// File: rtl/spi_sram_master.sv
// SPI mode-0 master for a 23A640-style serial SRAM: one 32-bit frame per byte request.
// Optional macro SPI_SRAM_MASTER_ADDR_CHECK_EN rejects addresses outside the 8 KB array.
module spi_sram_master #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_GAP     = 2,
  parameter logic [7:0]  READ_INST  = 8'h03,
  parameter logic [7:0]  WRITE_INST = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        csb,
  output logic        sck,
  output logic        si,
  input  logic        so
);

  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, GAP, ERR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  div_cnt;
  logic [4:0]  bit_cnt;
  logic [31:0] frame, frame_in;
  logic        is_read;
  logic [7:0]  rx;
  logic        accept, div_tc, gap_tc, bad_addr;

  always_comb begin
    accept   = req_valid && req_ready;
    div_tc   = (div_cnt == 8'(CLK_DIV - 1));
    gap_tc   = (div_cnt == 8'(CS_GAP - 1));
    frame_in = {req_write ? WRITE_INST : READ_INST, req_addr, req_write ? req_wdata : 8'h00};
`ifdef SPI_SRAM_MASTER_ADDR_CHECK_EN
    bad_addr = (req_addr[15:13] != 3'd0);
`else
    bad_addr = 1'b0;
`endif
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bad_addr ? ERR : SHIFT;
      SHIFT:   if (div_tc && sck && bit_cnt == 5'd31) state_nxt = HOLD;
      HOLD:    if (div_tc) state_nxt = GAP;
      GAP:     if (gap_tc) state_nxt = IDLE;
      ERR:     if (div_cnt == 8'd1) state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_ready <= 1'b0;
      csb       <= 1'b1;
      sck       <= 1'b0;
      si        <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      frame     <= '0;
      is_read   <= 1'b0;
      rx        <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      // one counter serves half-periods, HOLD, GAP and the error delay; it restarts on every state change
      if (state_nxt != state || state == IDLE || (state == SHIFT && div_tc)) div_cnt <= '0;
      else div_cnt <= div_cnt + 8'd1;
      case (state)
        IDLE: begin
          req_ready <= !accept;
          if (accept) begin
            frame   <= frame_in;
            is_read <= !req_write;
            bit_cnt <= '0;
            rx      <= 8'h00;
            if (!bad_addr) begin
              csb <= 1'b0;
              si  <= frame_in[31];
            end
          end
        end
        SHIFT: if (div_tc) begin
          sck <= !sck;
          if (sck) begin
            // falling sck: sample so for the data byte, then present the next bit
            bit_cnt <= bit_cnt + 5'd1;
            frame   <= {frame[30:0], 1'b0};
            si      <= frame[30];
            if (is_read && bit_cnt >= 5'd24) rx <= {rx[6:0], so};
          end
        end
        HOLD: if (div_tc) begin
          csb       <= 1'b1;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= is_read ? rx : 8'h00;
        end
        GAP: if (gap_tc) req_ready <= 1'b1;
`ifdef SPI_SRAM_MASTER_ADDR_CHECK_EN
        ERR: if (div_cnt == 8'd1) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= 8'h00;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sram_master.sv
// Bench: two masters (CLK_DIV=2/CS_GAP=2 and CLK_DIV=1/CS_GAP=3), each wired to a behavioural SRAM slave,
// checked against a byte-array model of memory contents and frame timing.
module tb_spi_sram_master;

  localparam int DIVS [2] = '{2, 1};
  localparam int GAPS [2] = '{2, 3};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]       req_valid, req_ready, req_write, rsp_valid, rsp_err;
  logic [1:0]       csb_w, sck_w, si_w, so_w;
  logic [1:0][15:0] req_addr;
  logic [1:0][7:0]  req_wdata, rsp_rdata;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_sram_master #(.CLK_DIV(2), .CS_GAP(2)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .csb(csb_w[0]), .sck(sck_w[0]), .si(si_w[0]), .so(so_w[0]));

  spi_sram_master #(.CLK_DIV(1), .CS_GAP(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .csb(csb_w[1]), .sck(sck_w[1]), .si(si_w[1]), .so(so_w[1]));

  // behavioural SRAM slaves: sample si on sck rise, drive so after each rise in the data phase
  logic [7:0]       mem [2][8192];
  logic [7:0]       exp_mem [2][8192];
  logic [1:0][31:0] sh, last_frame;
  logic [1:0][12:0] maddr;
  logic [1:0][7:0]  minst;
  logic [1:0]       csb_p, sck_p;
  int               rises [2];
  int               last_rises [2];
  int               nframes [2];

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (csb_w[g]) begin
        if (!csb_p[g]) last_rises[g] <= rises[g];
        rises[g] <= 0;
      end else if (sck_w[g] && !sck_p[g]) begin
        sh[g]    <= {sh[g][30:0], si_w[g]};
        rises[g] <= rises[g] + 1;
        if (rises[g] == 23) begin
          maddr[g] <= {sh[g][11:0], si_w[g]};
          minst[g] <= sh[g][22:15];
        end
        if (rises[g] >= 24 && minst[g] == 8'h03) so_w[g] <= mem[g][maddr[g]][31 - rises[g]];
        if (rises[g] == 31) begin
          last_frame[g] <= {sh[g][30:0], si_w[g]};
          nframes[g]    <= nframes[g] + 1;
          if (minst[g] == 8'h02) mem[g][maddr[g]] <= {sh[g][6:0], si_w[g]};
        end
      end
      csb_p[g] <= csb_w[g];
      sck_p[g] <= sck_w[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // issue one request on master g and check response, timing, and the frame the slave saw
  task automatic xfer(input int g, input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic hold);
    int   lat, gap, nf0;
    logic err_exp, rdy_seen, csb_bad, gap_bad;
    logic [7:0] rd_exp;
    err_exp = 1'b0;
`ifdef SPI_SRAM_MASTER_ADDR_CHECK_EN
    err_exp = (a[15:13] != 3'd0);
`endif
    rd_exp = (w || err_exp) ? 8'h00 : exp_mem[g][a[12:0]];
    nf0 = nframes[g];
    lat = 0;
    while (!req_ready[g] && lat < 20000) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ready_wait", 32'(req_ready[g]), 32'd1);
    req_valid[g] = 1'b1; req_write[g] = w; req_addr[g] = a; req_wdata[g] = d;
    @(posedge clk); #1;
    if (!hold) req_valid[g] = 1'b0;
    req_write[g] = 1'($urandom); req_addr[g] = 16'($urandom); req_wdata[g] = 8'($urandom);
    chk("csb_after_accept", 32'(csb_w[g]), 32'(err_exp));
    rdy_seen = 1'b0; csb_bad = 1'b0;
    for (lat = 1; lat <= 20000; lat++) begin
      @(posedge clk); #1;
      if (req_ready[g]) rdy_seen = 1'b1;
      if (rsp_valid[g]) break;
      if (csb_w[g] == !err_exp) csb_bad = 1'b1;
    end
    chk("rsp_latency", 32'(lat), err_exp ? 32'd2 : 32'(65 * DIVS[g]));
    chk("ready_low_in_frame", 32'(rdy_seen), 32'd0);
    chk("csb_in_frame", 32'(csb_bad), 32'd0);
    chk("rsp_err", 32'(rsp_err[g]), 32'(err_exp));
    chk("rsp_rdata", 32'(rsp_rdata[g]), 32'(rd_exp));
    chk("csb_high_at_rsp", 32'(csb_w[g]), 32'd1);
    gap = 0; gap_bad = 1'b0;
    while (!req_ready[g] && gap < 1000) begin
      @(posedge clk); #1;
      gap++;
      if (rsp_valid[g] || !csb_w[g] || sck_w[g]) gap_bad = 1'b1;
    end
    chk("ready_gap", 32'(gap), 32'(GAPS[g]));
    chk("gap_quiet", 32'(gap_bad), 32'd0);
    if (!err_exp) begin
      chk("frame_count", 32'(nframes[g]), 32'(nf0 + 1));
      chk("frame_bits", last_frame[g], {w ? 8'h02 : 8'h03, a, w ? d : 8'h00});
      chk("sck_rises", 32'(last_rises[g]), 32'd32);
      if (w) exp_mem[g][a[12:0]] = d;
    end else begin
      chk("no_frame", 32'(nframes[g]), 32'(nf0));
    end
  endtask

  initial begin
    logic [15:0] a;
    logic saw_rsp;
    for (int i = 0; i < 8192; i++) begin
      mem[0][i] = 8'h00; mem[1][i] = 8'h00; exp_mem[0][i] = 8'h00; exp_mem[1][i] = 8'h00;
    end
    for (int g = 0; g < 2; g++) begin
      rises[g] = 0; last_rises[g] = 0; nframes[g] = 0;
    end
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; so_w = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_csb", 32'(csb_w[g]), 32'd1);
      chk("rst_sck", 32'(sck_w[g]), 32'd0);
      chk("rst_si", 32'(si_w[g]), 32'd0);
      chk("rst_ready", 32'(req_ready[g]), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid[g]), 32'd0);
      chk("rst_rdata", 32'(rsp_rdata[g]), 32'd0);
      chk("rst_err", 32'(rsp_err[g]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'h3);

    xfer(0, 1'b1, 16'h0123, 8'hA5, 1'b0);
    xfer(0, 1'b0, 16'h0123, 8'h00, 1'b0);

    for (int i = 0; i < 4; i++) xfer(0, 1'b1, 16'(i), 8'($urandom), (i < 3) ? 1'b1 : 1'b0);
    for (int i = 0; i < 4; i++) xfer(0, 1'b0, 16'(i), 8'h00, 1'b0);

    xfer(1, 1'b1, 16'h1FFF, 8'h3C, 1'b0);
    xfer(1, 1'b0, 16'h1FFF, 8'h00, 1'b0);

    // abandon a write mid-address-phase with reset; the byte must never land
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 16'h0010; req_wdata[0] = 8'hFF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    saw_rsp = 1'b0;
    repeat (39) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) saw_rsp = 1'b1;
    end
    chk("mid_frame_csb_low", 32'(csb_w[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_csb", 32'(csb_w[0]), 32'd1);
    chk("abort_sck", 32'(sck_w[0]), 32'd0);
    if (rsp_valid[0]) saw_rsp = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (rsp_valid[0]) saw_rsp = 1'b1;
    end
    chk("abort_no_rsp", 32'(saw_rsp), 32'd0);
    xfer(0, 1'b0, 16'h0010, 8'h00, 1'b0);

    xfer(0, 1'b0, 16'h2000, 8'h00, 1'b0);

    for (int n = 0; n < 60; n++) begin
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a[15:13] = 3'($urandom_range(1, 7));
      xfer(n % 2, 1'($urandom), a, 8'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
